// File: rtl/src_frame_buf.sv
// Double-buffered raster frame source for lenet: one bank fills from a pixel
// stream while the consumer reads the other through the cena/aa/qa port.
module src_frame_buf #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int IN_W    = 8,
    parameter int DW      = 9,
    parameter int PIX_MAX = 255,
    parameter int AW      = $clog2(IMG_W * IMG_H)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    input  logic            abort,
    output logic            go,
    input  logic            ready,
    input  logic            cena,
    input  logic [AW-1:0]   aa,
    output logic [DW-1:0]   qa,
    output logic [15:0]     frames_in,
    output logic [15:0]     frames_done
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_BUSY} bank_st_t;
    typedef enum logic {RD_IDLE, RD_RUN} rd_st_t;

    bank_st_t      bst_q [2];
    bank_st_t      bst_d [2];
    rd_st_t        rd_q, rd_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          in_ready_q, in_ready_d;
    logic [15:0]   fin_q, fin_d;
    logic [15:0]   fdone_q, fdone_d;
    logic [DW-1:0] qa_q;
    logic          wr_en;
    logic          go_d;
    logic [DW-1:0] mem_q [2][DEPTH];

    function automatic logic [DW-1:0] sat_pix(input logic [IN_W-1:0] px);
        if (32'(px) > 32'(PIX_MAX)) return DW'(PIX_MAX);
        return DW'(px);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bst_q[0]   <= B_EMPTY;
            bst_q[1]   <= B_EMPTY;
            rd_q       <= RD_IDLE;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            waddr_q    <= '0;
            in_ready_q <= 1'b0;
            fin_q      <= '0;
            fdone_q    <= '0;
        end else begin
            bst_q[0]   <= bst_d[0];
            bst_q[1]   <= bst_d[1];
            rd_q       <= rd_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            waddr_q    <= waddr_d;
            in_ready_q <= in_ready_d;
            fin_q      <= fin_d;
            fdone_q    <= fdone_d;
        end
    end

    // Write side and read FSM never touch the same bank in one cycle: writes
    // need an EMPTY bank, the FSM only acts on a FULL or BUSY one.
    always_comb begin
        bst_d[0] = bst_q[0];
        bst_d[1] = bst_q[1];
        rd_d     = rd_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        waddr_d  = waddr_q;
        fin_d    = fin_q;
        fdone_d  = fdone_q;
        wr_en    = 1'b0;
        go_d     = 1'b0;
        if (abort) begin
            bst_d[0] = B_EMPTY;
            bst_d[1] = B_EMPTY;
            rd_d     = RD_IDLE;
            wb_d     = 1'b0;
            rb_d     = 1'b0;
            waddr_d  = '0;
        end else begin
            if (in_valid && in_ready_q) begin
                wr_en = 1'b1;
                if (waddr_q == LAST_ADDR) begin
                    bst_d[wb_q] = B_FULL;
                    wb_d        = ~wb_q;
                    waddr_d     = '0;
                    fin_d       = fin_q + 16'd1;
                end else begin
                    waddr_d = waddr_q + AW'(1);
                end
            end
            case (rd_q)
                RD_IDLE: begin
                    if (bst_q[rb_q] == B_FULL) begin
                        go_d        = 1'b1;
                        bst_d[rb_q] = B_BUSY;
                        rd_d        = RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (ready) begin
                        bst_d[rb_q] = B_EMPTY;
                        rb_d        = ~rb_q;
                        fdone_d     = fdone_q + 16'd1;
                        rd_d        = RD_IDLE;
                    end
                end
                default: rd_d = RD_IDLE;
            endcase
        end
        in_ready_d = (bst_d[wb_d] == B_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wb_q][waddr_q] <= sat_pix(in_data);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qa_q <= '0;
        end else if (!cena) begin
            qa_q <= (32'(aa) < 32'(DEPTH)) ? mem_q[rb_q][aa] : '0;
        end
    end

    assign in_ready    = in_ready_q;
    assign go          = go_d;
    assign qa          = qa_q;
    assign frames_in   = fin_q;
    assign frames_done = fdone_q;

endmodule

// File: doc/src_frame_buf.md
# src_frame_buf

Parametrised, double-buffered image source for the `lenet` core. It accepts a raster-ordered pixel stream into one bank while `lenet` reads the other through the same `cena`/`aa`/`qa` port it uses today. It sequences frames with a `go`/`ready` handshake and generalises the fixed 32x32 ROM source to arbitrary frame size, pixel width and saturation limit. Synthesisable; sits between the frame loader (bench or DMA) and `lenet`.

## Interface
- `IMG_W`, 32, frame width in pixels
- `IMG_H`, 32, frame height in pixels
- `IN_W`, 8, input pixel width
- `DW`, 9, stored/output pixel width (`` `WD ``+1)
- `PIX_MAX`, 255, saturation ceiling; input values above it are stored as `PIX_MAX`
- `AW`, $clog2(IMG_W*IMG_H), read address width (derived)

- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input pixel valid
- `in_data`  in  IN_W  pixel, raster order, unsigned
- `in_ready`  out  1  buffer can accept a pixel
- `abort`  in  1  synchronous flush of all banks and FSMs
- `go`  out  1  one-cycle pulse: frame available in read bank
- `ready`  in  1  consumer done with current frame (pulse)
- `cena`  in  1  read enable, active-low
- `aa`  in  AW  read address within the current read bank
- `qa`  out  DW  read data, registered
- `frames_in`  out  16  completed frame loads, wraps
- `frames_done`  out  16  frames released by `ready`, wraps

## Operation
- Two banks, each IMG_W*IMG_H x DW. Each bank has a state: EMPTY, FULL or BUSY. Write bank pointer `wb` and read bank pointer `rb` both reset to 0.
- Write side:
  - `in_ready` = (state[wb]==EMPTY), registered.
  - A pixel is accepted when `in_valid && in_ready`. It is stored at `waddr` in bank `wb`; `waddr` then increments.
  - Stored value = min(`in_data`, `PIX_MAX`), zero-extended to DW.
  - On acceptance at `waddr`==IMG_W*IMG_H-1: state[wb]<=FULL, `wb` toggles, `waddr`<=0, `frames_in`++.
- Read FSM:
  - IDLE: if state[rb]==FULL, assert `go` for one cycle, set state[rb]<=BUSY and move to RUN.
  - RUN: on `ready`, state[rb]<=EMPTY, `rb` toggles, `frames_done`++, return to IDLE.
  - `ready` in IDLE is ignored.
- Read port:
  - `cena`==0: `qa` <= bank[rb][aa] on the next edge.
  - `cena`==1: `qa` holds its value.
  - Reads outside RUN still return bank[rb] contents; they are harmless.
  - `aa` >= IMG_W*IMG_H returns 0.
- `abort`:
  - All banks <= EMPTY; `wb`, `rb`, `waddr` <= 0; FSM <= IDLE.
  - `go` is suppressed that cycle. Counters are not cleared.
  - `abort` has priority over every same-cycle event.
- Simultaneous events:
  - A last-pixel write to one bank and `ready` releasing the other bank in the same cycle both take effect.
  - A bank released by `ready` becomes writable with `in_ready`=1 on the following cycle.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first edge after release; `go`=0; `qa`=0; `frames_in`=0; `frames_done`=0; all banks EMPTY; FSM IDLE.
- Reset mid-frame discards all contents. No `go` is issued until a complete new frame has been loaded.
- Write-to-go latency: last pixel accepted at edge N, state FULL visible at N, `go` high during cycle N+1 (earliest).
- `go` is never asserted in RUN. Two `go` pulses are separated by at least one `ready`.
- Read latency: 1 cycle (address at edge N, data valid after edge N+1), identical to the existing source ROM.
- `in_ready` drops in the cycle after the last pixel of a frame only if state[wb] (the new write bank) is not EMPTY.
- Throughput: one pixel per cycle sustained while the consumer keeps up. Frame N+1 loads while frame N is processed.

## Test plan
- Single frame: reset, stream 1024 pixels with value = index mod 256 and no gaps.
  - `go` pulses exactly once, 1 cycle after the last accept.
  - Reads of `aa`=0, 5, 1023 return 0, 5, 255 one cycle later. `frames_in`=1.
- Ping-pong backpressure: stream 3 frames back-to-back with `ready` withheld.
  - `in_ready` falls after frame 2 completes; frame 3 stalls.
  - Pulse `ready`: `in_ready` rises next cycle, second `go` follows, and frame 3 completes. `frames_done`=1 after the pulse.
- Saturation: `IN_W`=10, `PIX_MAX`=255, input values 256, 300, 1023, 100 → stored 255, 255, 255, 100.
- Abort mid-fill: assert `abort` after 500 pixels of frame 2 while frame 1 is BUSY.
  - No `go` follows and `in_ready`=1.
  - A fresh 1024-pixel frame then produces `go`, and reads return the new data.
- Simultaneous: time the last pixel of frame 2 to coincide with `ready` for frame 1.
  - `go` for frame 2 occurs in the next cycle.
  - `frames_in`=2 and `frames_done`=1, with no lost frame.
- Reset mid-RUN: drop `rstn` asynchronously mid-cycle.
  - `go`, `qa` and the counters read 0 immediately and all banks are EMPTY.
  - Normal operation resumes after release.
